// File: rtl/adc_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module  : adc_sample_buffer
// Brief   : Fixed-length ADC capture window with min/max tracking and a
//           sticky out-of-band fault flag; capture RAM readable at any time.
// Rev     : 1.0  initial release
// ============================================================================
module adc_sample_buffer #(
  parameter int          DEPTH      = 64,
  parameter int          ADDR_W     = 6,
  parameter logic [11:0] THRESH_LO  = 12'd500,
  parameter logic [11:0] THRESH_HI  = 12'd3500,
  parameter int          FAIL_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       sample_in,
  input  logic              sample_valid,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [11:0]       rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count,
  output logic [11:0]       min_val,
  output logic [11:0]       max_val,
  output logic              fault
);

  localparam int              c_CW    = ADDR_W + 1;
  localparam logic [ADDR_W:0] c_LAST  = c_CW'(DEPTH - 1);
  localparam logic [3:0]      c_FAIL  = 4'(FAIL_COUNT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_count;
  logic [11:0]       r_min;
  logic [11:0]       r_max;
  logic [3:0]        r_run;
  logic              r_fault;
  logic [11:0]       r_rd_data;
  logic              r_rd_valid;
  logic [11:0]       r_mem [0:DEPTH-1];

  logic              w_accept;
  logic              w_oob;
  logic [3:0]        w_run_next;

  // start has priority: a sample arriving with start is dropped
  assign w_accept = (r_state == S_CAPTURE) && sample_valid && !start;
  assign w_oob    = (sample_in < THRESH_LO) || (sample_in > THRESH_HI);

  always_comb begin
    w_run_next = r_run;
    if (w_oob) begin
      if (r_run != c_FAIL) w_run_next = r_run + 4'd1;
    end else begin
      w_run_next = 4'd0;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_min   <= 12'hFFF;
      r_max   <= 12'h000;
      r_run   <= 4'd0;
      r_fault <= 1'b0;
    end else if (start) begin
      r_state <= S_CAPTURE;
      r_count <= '0;
      r_min   <= 12'hFFF;
      r_max   <= 12'h000;
      r_run   <= 4'd0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
      if (sample_in < r_min) r_min <= sample_in;
      if (sample_in > r_max) r_max <= sample_in;
      r_run <= w_run_next;
      if (w_run_next == c_FAIL) r_fault <= 1'b1;
      if (r_count == c_LAST) r_state <= S_DONE;
    end
  end

  always_ff @(negedge clk) begin
    if (w_accept) r_mem[r_count[ADDR_W-1:0]] <= sample_in;
  end

  // Non-blocking read of the old word gives read-before-write on a collision
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= 12'h000;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign busy         = (r_state == S_CAPTURE);
  assign done         = (r_state == S_DONE);
  assign sample_count = r_count;
  assign min_val      = r_min;
  assign max_val      = r_max;
  assign fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_buffer.sv
`default_nettype none
// Testbench for adc_sample_buffer: directed scenarios plus randomized windows
// checked against a queue-based model of the capture window.
module tb_adc_sample_buffer;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int LO     = 500;
  localparam int HI     = 3500;
  localparam int FAILN  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [11:0]       sample_in;
  logic              sample_valid;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sample_count;
  logic [11:0]       min_val;
  logic [11:0]       max_val;
  logic              fault;

  int total = 0;
  int bad   = 0;

  // Model: the window is simply the list of accepted samples
  logic [11:0] m_hist[$];
  bit          m_cap;
  bit          m_done;

  adc_sample_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_in(sample_in),
    .sample_valid(sample_valid), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .sample_count(sample_count), .min_val(min_val), .max_val(max_val),
    .fault(fault)
  );

  always #10 clk = ~clk;

  function automatic logic [11:0] f_min();
    logic [11:0] m = 12'hFFF;
    foreach (m_hist[i]) if (m_hist[i] < m) m = m_hist[i];
    return m;
  endfunction

  function automatic logic [11:0] f_max();
    logic [11:0] m = 12'h000;
    foreach (m_hist[i]) if (m_hist[i] > m) m = m_hist[i];
    return m;
  endfunction

  function automatic bit f_fault();
    int run = 0;
    bit f = 0;
    foreach (m_hist[i]) begin
      if (m_hist[i] < LO || m_hist[i] > HI) begin
        run++;
        if (run >= FAILN) f = 1;
      end else run = 0;
    end
    return f;
  endfunction

  // Inputs change at posedge; the DUT acts on the following negedge.
  task automatic step(input bit st, input bit sv, input logic [11:0] s);
    start = st; sample_valid = sv; sample_in = s;
    @(posedge clk);
    if (st) begin
      m_cap = 1; m_done = 0; m_hist.delete();
    end else if (sv && m_cap) begin
      m_hist.push_back(s);
      if (m_hist.size() == DEPTH) begin m_cap = 0; m_done = 1; end
    end
    start = 0; sample_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; sample_valid = 0; sample_in = 0; rd_req = 0; rd_addr = 0;
    m_cap = 0; m_done = 0; m_hist.delete();
    repeat (2) @(posedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", done); end
    total++; if (sample_count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", sample_count); end
    total++; if (min_val !== 12'hFFF) begin bad++; $display("FAIL reset_min got=%h exp=fff", min_val); end
    total++; if (max_val !== 12'h000) begin bad++; $display("FAIL reset_max got=%h exp=000", max_val); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0d exp=0", fault); end
    total++; if ({rd_valid, rd_data} !== 13'h0) begin bad++; $display("FAIL reset_rd got=%0d/%h exp=0/000", rd_valid, rd_data); end
    rst = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_ramp();
    step(1, 0, 12'h0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp_busy got=%0d exp=1", busy); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 12'h100 + 12'(i));
      if (i == DEPTH - 2) begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL ramp_early_done got=%0d exp=0", done); end
      end
    end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ramp_done got=done%0d/busy%0d exp=1/0", done, busy); end
    total++; if (sample_count !== 7'd64) begin bad++; $display("FAIL ramp_count got=%0d exp=64", sample_count); end
    total++; if (min_val !== 12'h100 || max_val !== 12'h13F) begin bad++; $display("FAIL ramp_minmax got=%h/%h exp=100/13f", min_val, max_val); end
    step(0, 1, 12'hFFF);
    total++; if (sample_count !== 7'd64 || max_val !== 12'h13F) begin bad++; $display("FAIL ramp_done_ignore got=%0d/%h exp=64/13f", sample_count, max_val); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_req = 1; rd_addr = 6'(a);
      @(posedge clk);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 12'h100 + 12'(a)) begin
        bad++; $display("FAIL ramp_read addr=%0d got=%0d/%h exp=1/%h", a, rd_valid, rd_data, 12'h100 + 12'(a));
      end
    end
    rd_req = 0;
    @(posedge clk);
    total++; if (rd_valid !== 1'b0 || rd_data !== 12'h13F) begin bad++; $display("FAIL ramp_rd_hold got=%0d/%h exp=0/13f", rd_valid, rd_data); end
  endtask

  task automatic test_fault_seq();
    logic [11:0] seq [6] = '{12'h7D0, 12'h100, 12'hFA0, 12'h050, 12'hE00, 12'h7D0};
    bit          expf[6] = '{0, 0, 0, 0, 1, 1};
    step(1, 0, 12'h0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, seq[i]);
      total++; if (fault !== expf[i]) begin bad++; $display("FAIL fault_seq idx=%0d got=%0d exp=%0d", i, fault, expf[i]); end
    end
    while (!m_done) step(0, 1, 12'h800);
    total++; if (fault !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL fault_sticky got=fault%0d/done%0d exp=1/1", fault, done); end
  endtask

  task automatic test_thresholds();
    step(1, 0, 12'h0);
    for (int i = 0; i < 20; i++) step(0, 1, (i % 2) ? 12'hDAC : 12'h1F4);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL thresh_fault got=%0d exp=0", fault); end
    total++; if (min_val !== 12'h1F4 || max_val !== 12'hDAC) begin bad++; $display("FAIL thresh_minmax got=%h/%h exp=1f4/dac", min_val, max_val); end
  endtask

  task automatic test_run_clear();
    logic [11:0] seq [7] = '{12'h000, 12'hFFF, 12'h1F3, 12'h1F4, 12'hDAD, 12'h010, 12'hF00};
    step(1, 0, 12'h0);
    foreach (seq[i]) step(0, 1, seq[i]);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL run_clear got=%0d exp=0", fault); end
    step(0, 1, 12'h001);
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL run_fourth got=%0d exp=1", fault); end
  endtask

  task automatic test_start_collision();
    step(1, 0, 12'h0);
    for (int i = 0; i < 20; i++) step(0, 1, 12'($urandom_range(0, 4095)));
    step(1, 1, 12'hABC);
    total++; if (sample_count !== 7'd0 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL coll_state got=%0d/%0d/%0d exp=0/1/0", sample_count, busy, done); end
    total++; if (min_val !== 12'hFFF || max_val !== 12'h000 || fault !== 1'b0) begin bad++; $display("FAIL coll_stats got=%h/%h/%0d exp=fff/000/0", min_val, max_val, fault); end
    step(0, 1, 12'h222);
    rd_req = 1; rd_addr = 6'd0;
    @(posedge clk);
    rd_req = 0;
    total++; if (rd_data !== 12'h222 || sample_count !== 7'd1) begin bad++; $display("FAIL coll_first got=%h/%0d exp=222/1", rd_data, sample_count); end
  endtask

  task automatic test_random();
    for (int w = 0; w < 4; w++) begin
      step(1, 0, 12'h0);
      while (!m_done) begin
        logic [11:0] s;
        if ($urandom_range(0, 3) == 0) s = 12'($urandom_range(0, 4095));
        else if ($urandom_range(0, 1) == 0) s = 12'($urandom_range(LO, HI));
        else s = (w % 2) ? 12'($urandom_range(HI + 1, 4095)) : 12'($urandom_range(0, LO - 1));
        step(0, 1, s);
        total++; if (sample_count !== 7'(m_hist.size())) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", sample_count, m_hist.size()); end
        total++; if (min_val !== f_min() || max_val !== f_max()) begin bad++; $display("FAIL rnd_minmax got=%h/%h exp=%h/%h", min_val, max_val, f_min(), f_max()); end
        total++; if (fault !== f_fault()) begin bad++; $display("FAIL rnd_fault got=%0d exp=%0d", fault, f_fault()); end
        total++; if (done !== m_done || busy !== m_cap) begin bad++; $display("FAIL rnd_state got=%0d/%0d exp=%0d/%0d", done, busy, m_done, m_cap); end
        if ($urandom_range(0, 3) == 0) step(0, 0, 12'h0);
      end
      for (int k = 0; k < 8; k++) begin
        int a = $urandom_range(0, DEPTH - 1);
        rd_req = 1; rd_addr = 6'(a);
        @(posedge clk);
        rd_req = 0;
        total++; if (rd_valid !== 1'b1 || rd_data !== m_hist[a]) begin bad++; $display("FAIL rnd_read addr=%0d got=%h exp=%h", a, rd_data, m_hist[a]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 12'h0);
    for (int i = 0; i < 30; i++) step(0, 1, 12'(i * 37));
    #3 rst = 1'b0;
    #1;
    m_cap = 0; m_done = 0; m_hist.delete();
    total++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 7'd0) begin bad++; $display("FAIL rstmid_state got=%0d/%0d/%0d exp=0/0/0", busy, done, sample_count); end
    total++; if (min_val !== 12'hFFF || max_val !== 12'h000 || fault !== 1'b0) begin bad++; $display("FAIL rstmid_stats got=%h/%h/%0d exp=fff/000/0", min_val, max_val, fault); end
    @(posedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 1, 12'h050);
    total++; if (sample_count !== 7'd0 || busy !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL rstmid_ignore got=%0d/%0d/%0d exp=0/0/0", sample_count, busy, fault); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_fault_seq();
    test_thresholds();
    test_run_clear();
    test_start_collision();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_sample_buffer.md
Name: adc_sample_buffer

Overview:
Downstream consumer of the 12-bit ADC serial-capture stage.
- Accepts one completed 12-bit conversion per `sample_valid` pulse.
- Records a fixed-length capture window into an internal circular RAM.
- Tracks the window minimum and maximum.
- Raises a sticky `fault` flag when consecutive samples fall outside the healthy band; this is the primary circuit-failure indicator for the twinning comparison.
- The capture RAM is readable after the window completes.

Parameters:
DEPTH, 64, number of samples per capture window (power of two, 2..1024)
ADDR_W, 6, log2(DEPTH)
THRESH_LO, 12'd500, lowest in-band sample value (inclusive)
THRESH_HI, 12'd3500, highest in-band sample value (inclusive)
FAIL_COUNT, 4, consecutive out-of-band samples that set `fault` (1..15)

Ports:
clk  input  1  50 MHz system clock; all logic on its negative edge
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: clear statistics and begin a new capture window
sample_in  input  12  conversion result from ADC capture stage
sample_valid  input  1  one-cycle pulse: `sample_in` holds a new, stable result
rd_req  input  1  read strobe for capture RAM
rd_addr  input  ADDR_W  read address (0 = oldest sample of window)
rd_data  output  12  RAM read data
rd_valid  output  1  `rd_data` valid pulse
busy  output  1  high while capturing
done  output  1  high once DEPTH samples stored; cleared by `start`
sample_count  output  ADDR_W+1  samples stored in current window
min_val  output  12  smallest sample in window
max_val  output  12  largest sample in window
fault  output  1  sticky out-of-band failure flag

Behaviour:
- Reset state: state=IDLE.
  - Outputs: `busy`=0, `done`=0, `sample_count`=0, `min_val`=12'hFFF, `max_val`=12'h000, `fault`=0, `rd_data`=0, `rd_valid`=0.
  - Internal: the out-of-band run counter is 0. RAM contents are undefined.
- Reset asserted mid-capture: abort immediately to the reset state. No partial `done`.
- States: IDLE, CAPTURE, DONE.
  - IDLE --start--> CAPTURE
  - CAPTURE --DEPTH-th sample written--> DONE
  - DONE --start--> CAPTURE
  - `start` in CAPTURE restarts the window (same clear actions); it does not return to IDLE.
- On `start`, in the same cycle:
  - Clear `sample_count`, the write pointer and the run counter.
  - Set `min_val`=FFF, `max_val`=000, `fault`=0, `done`=0, `busy`=1.
- `start` and `sample_valid` in the same cycle: `start` wins; that sample is discarded.
- CAPTURE, on `sample_valid`, all updates register on that edge:
  - Write `sample_in` to RAM[`sample_count`].
  - Increment `sample_count`.
  - Update `min_val`/`max_val` with unsigned compare; a sample equal to the current extreme leaves it unchanged.
- When the write makes `sample_count`==DEPTH:
  - Next state is DONE; `busy`=0 and `done`=1 one edge after that write.
  - `sample_count` holds at DEPTH; there is no wrap within a window.
- `sample_valid` in IDLE or DONE: ignored. No RAM write, statistics unchanged, `fault` logic unchanged.
- Band check, CAPTURE only:
  - Out-of-band means `sample_in` < THRESH_LO or `sample_in` > THRESH_HI.
  - Each out-of-band sample increments the run counter, saturating at FAIL_COUNT.
  - Each in-band sample clears the run counter.
  - When the counter reaches FAIL_COUNT, `fault`=1 on that same edge.
  - `fault` stays set until `start` or reset.
  - Samples exactly equal to THRESH_LO or THRESH_HI are in-band.
- Read port:
  - `rd_req` in any state registers RAM[`rd_addr`] into `rd_data`.
  - `rd_valid`=1 exactly one edge later, for one cycle; `rd_data` holds until the next read.
  - A read of an address not yet written in the current window returns stale or undefined data. The bench must only check addresses below `sample_count`.
  - Simultaneous read and write to the same address returns the old data (read-before-write).
- Latency:
  - `sample_valid` to statistic/`fault` update: 1 edge.
  - `rd_req` to `rd_valid`: 1 edge.
- Back-to-back `sample_valid` on every cycle must be accepted. The upstream stage delivers one sample per ~10 us, so this is a design margin, not an expected case.

Test Plan:
- Reset, then `start`, then 64 samples 0x100,0x101,...,0x13F → `done`=1 one edge after the 64th; `sample_count`=64; `min_val`=0x100; `max_val`=0x13F; reads of addr 0..63 return 0x100+addr with `rd_valid` one edge after each `rd_req`.
- In CAPTURE, feed 0x7D0,0x100,0xFA0,0x050,0xE00,0x7D0 → `fault` rises on the 0xE00 edge (4th consecutive out-of-band); still 1 after the in-band 0x7D0 and after `done`.
- Feed 0x1F4 and 0xDAC (exact thresholds) interleaved ×10 → `fault` stays 0; `min_val`=0x1F4; `max_val`=0xDAC.
- Feed 3 out-of-band, 1 in-band, 3 out-of-band → `fault`=0 (run counter cleared by the in-band sample).
- After 20 samples, pulse `start` together with `sample_valid`=1 → `sample_count`=0, statistics reset, `fault`=0, sample discarded, `busy`=1.
- Assert `rst`=0 mid-capture after 30 samples, then release → IDLE with all outputs at reset values; `sample_valid` pulses without `start` → `sample_count` stays 0.
